fpu_scheduler: RTL and testbench

FPU_SCHEDULER -- requirements
Module: fpu_scheduler

---
 rtl/fpu_pkg.sv | 22 ++
 rtl/fpu_rr_arb2.sv | 18 +
 rtl/rvdffe.sv | 23 ++
 rtl/fpu_scheduler.sv | 137 +++++++++++++
 tb/tb_fpu_scheduler.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU command scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fpu_pkg;

  localparam int OP_W = 13;
  localparam logic [OP_W-1:0] LEGAL_OP_MASK = 13'h1FFC;
  localparam int TIMEOUT_CYCLES_DEF = 1024;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // An op is legal when it selects exactly one datapath unit in [12:2].
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return ((op & ~LEGAL_OP_MASK) == '0) && $onehot(op);
  endfunction

endpackage

// File: rtl/fpu_rr_arb2.sv
// Two-way round-robin grant; prio names the winner on a tie.
// Latency: combinational.
// Backpressure: none; gnt is zero when nobody requests.
// Ports: req[1:0], prio, gnt[1:0] (one-hot).
module fpu_rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = prio ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/rvdffe.sv
// Enabled flop cell with synchronous active-high clear.
// Latency: 1 cycle from din to dout when en is high.
// Backpressure: none; en low holds the stored value.
// Ports: clk, rst (sync clear), en (load), din, dout.
module rvdffe #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else if (en) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/fpu_scheduler.sv
// Two-requester scheduler issuing one op at a time to a shared FPU datapath.
// Latency: accept -> rsp_valid in 3 cycles minimum (1 cycle for illegal ops).
// Backpressure: rsp_valid holds until rsp_ready of the granted requester; no new accept meanwhile.
// Ports: req_* command side, fpu_* datapath side, rsp_* response side; clk, rst (sync, active-high).
// Config: FPU_SCHED_TIMEOUT_EN enables the WAIT-state timeout of TIMEOUT_CYCLES cycles.
module fpu_scheduler
  import fpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [25:0] req_op,
  input  logic [63:0] req_opa,
  input  logic [63:0] req_opb,
  input  logic [63:0] req_opc,
  input  logic [5:0]  req_frm,
  output logic [31:0] fpu_opa,
  output logic [31:0] fpu_opb,
  output logic [31:0] fpu_opc,
  output logic [2:0]  fpu_frm,
  output logic [12:0] fpu_op_valid,
  input  logic [12:0] fpu_valids,
  input  logic [31:0] fpu_result,
  input  logic [4:0]  fpu_exceptions,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_result,
  output logic [4:0]  rsp_flags,
  output logic        rsp_err,
  output logic        rsp_timeout
);

  state_t            state_q, state_nxt;
  logic [1:0]        state_raw;
  logic              prio_q, grant_q;
  logic [1:0]        gnt;
  logic              accept, done, resp_done, tmo_hit, sel_legal;
  logic [OP_W-1:0]   sel_op, op_q;
  logic [31:0]       sel_opa, sel_opb, sel_opc, opa_q, opb_q, opc_q, result_q;
  logic [2:0]        sel_frm, frm_q;
  logic [4:0]        flags_q;
  logic              err_q;

  fpu_rr_arb2 u_arb (.req(req_valid), .prio(prio_q), .gnt(gnt));

  // Only the upper requester's grant bit is needed to pick its slice.
  assign sel_op    = gnt[1] ? req_op[25:13]  : req_op[12:0];
  assign sel_opa   = gnt[1] ? req_opa[63:32] : req_opa[31:0];
  assign sel_opb   = gnt[1] ? req_opb[63:32] : req_opb[31:0];
  assign sel_opc   = gnt[1] ? req_opc[63:32] : req_opc[31:0];
  assign sel_frm   = gnt[1] ? req_frm[5:3]   : req_frm[2:0];
  assign sel_legal = op_legal(sel_op);

  // rst gates accept so a reset cycle never looks like a handshake.
  assign accept    = (state_q == S_IDLE) && (|req_valid) && !rst;
  assign done      = (state_q == S_WAIT) && (|(fpu_valids & LEGAL_OP_MASK));
  assign resp_done = (state_q == S_RESP) && rsp_ready[grant_q];

  // State register
  rvdffe #(.WIDTH(2)) u_state_ff (.clk(clk), .rst(rst), .en(1'b1), .din(state_nxt), .dout(state_raw));
  assign state_q = state_t'(state_raw);

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_nxt = sel_legal ? S_ISSUE : S_RESP;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (done || tmo_hit) state_nxt = S_RESP;
      S_RESP:  if (resp_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready    = accept ? gnt : 2'b00;
    fpu_op_valid = (state_q == S_ISSUE) ? op_q : '0;
    rsp_valid    = 2'b00;
    if (state_q == S_RESP) begin
      rsp_valid = grant_q ? 2'b10 : 2'b01;
    end
  end

  // Command capture
  rvdffe #(.WIDTH(1))    u_grant_ff (.clk(clk), .rst(rst), .en(accept), .din(gnt[1]),     .dout(grant_q));
  rvdffe #(.WIDTH(OP_W)) u_op_ff    (.clk(clk), .rst(rst), .en(accept), .din(sel_op),     .dout(op_q));
  rvdffe #(.WIDTH(32))   u_opa_ff   (.clk(clk), .rst(rst), .en(accept), .din(sel_opa),    .dout(opa_q));
  rvdffe #(.WIDTH(32))   u_opb_ff   (.clk(clk), .rst(rst), .en(accept), .din(sel_opb),    .dout(opb_q));
  rvdffe #(.WIDTH(32))   u_opc_ff   (.clk(clk), .rst(rst), .en(accept), .din(sel_opc),    .dout(opc_q));
  rvdffe #(.WIDTH(3))    u_frm_ff   (.clk(clk), .rst(rst), .en(accept), .din(sel_frm),    .dout(frm_q));
  rvdffe #(.WIDTH(1))    u_err_ff   (.clk(clk), .rst(rst), .en(accept), .din(!sel_legal), .dout(err_q));

  // Result is cleared on accept so error and timeout responses return zero.
  rvdffe #(.WIDTH(32)) u_res_ff (.clk(clk), .rst(rst), .en(accept || done),
                                 .din(done ? fpu_result : 32'd0), .dout(result_q));
  rvdffe #(.WIDTH(5))  u_flg_ff (.clk(clk), .rst(rst), .en(accept || done),
                                 .din(done ? fpu_exceptions : 5'd0), .dout(flags_q));

  // Winner of the finished op yields priority to the other requester.
  rvdffe #(.WIDTH(1)) u_prio_ff (.clk(clk), .rst(rst), .en(resp_done), .din(!grant_q), .dout(prio_q));

`ifdef FPU_SCHED_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             tmo_q;

  // Counter holds the number of WAIT cycles already elapsed; ISSUE clears it.
  assign cnt_nxt = (state_q == S_ISSUE) ? '0 : cnt_q + CNT_W'(1);
  // A completion on the limit cycle takes precedence over the timeout.
  assign tmo_hit = (state_q == S_WAIT) && !done && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  rvdffe #(.WIDTH(CNT_W)) u_cnt_ff (.clk(clk), .rst(rst),
                                    .en((state_q == S_ISSUE) || (state_q == S_WAIT)),
                                    .din(cnt_nxt), .dout(cnt_q));
  rvdffe #(.WIDTH(1)) u_tmo_ff (.clk(clk), .rst(rst), .en(accept || tmo_hit),
                                .din(tmo_hit), .dout(tmo_q));
  assign rsp_timeout = tmo_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES > 0);
  assign tmo_hit        = 1'b0;
  assign rsp_timeout    = 1'b0;
`endif

  assign fpu_opa    = opa_q;
  assign fpu_opb    = opb_q;
  assign fpu_opc    = opc_q;
  assign fpu_frm    = frm_q;
  assign rsp_result = result_q;
  assign rsp_flags  = flags_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_fpu_scheduler.sv
// Directed bench for fpu_scheduler with hand-computed expectations.
// Latency: n/a.
// Backpressure: rsp_ready driven explicitly per test.
module tb_fpu_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [25:0] req_op;
  logic [63:0] req_opa, req_opb, req_opc;
  logic [5:0]  req_frm;
  logic [31:0] fpu_opa, fpu_opb, fpu_opc, fpu_result, rsp_result;
  logic [2:0]  fpu_frm;
  logic [12:0] fpu_op_valid, fpu_valids;
  logic [4:0]  fpu_exceptions, rsp_flags;
  logic        rsp_err, rsp_timeout;

  int total = 0;
  int bad   = 0;

  fpu_scheduler #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_opa(req_opa), .req_opb(req_opb), .req_opc(req_opc), .req_frm(req_frm),
    .fpu_opa(fpu_opa), .fpu_opb(fpu_opb), .fpu_opc(fpu_opc), .fpu_frm(fpu_frm),
    .fpu_op_valid(fpu_op_valid), .fpu_valids(fpu_valids),
    .fpu_result(fpu_result), .fpu_exceptions(fpu_exceptions),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; all driving and sampling happens 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [12:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] c, input logic [2:0] frm);
    req_op[13*i +: 13]  = op;
    req_opa[32*i +: 32] = a;
    req_opb[32*i +: 32] = b;
    req_opc[32*i +: 32] = c;
    req_frm[3*i +: 3]   = frm;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = '0; req_op = '0;
    req_opa = '0; req_opb = '0; req_opc = '0; req_frm = '0;
    fpu_valids = '0; fpu_result = '0; fpu_exceptions = '0;
    tick(); tick();

    // Reset state
    chk("rst_req_ready",   req_ready, 2'b00);
    chk("rst_rsp_valid",   rsp_valid, 2'b00);
    chk("rst_op_valid",    fpu_op_valid, 13'h0);
    chk("rst_err",         rsp_err, 1'b0);
    chk("rst_timeout",     rsp_timeout, 1'b0);
    chk("rst_opa",         fpu_opa, 32'h0);
    rst = 1'b0;

    // Single add from requester 0, completes after 2 WAIT cycles
    set_req(0, 13'h0004, 32'h3F800000, 32'h40000000, 32'h0, 3'd1);
    req_valid = 2'b01;
    #1;
    chk("t1_req_ready", req_ready, 2'b01);
    tick();                               // ISSUE
    req_valid = 2'b00;
    fpu_valids = 13'h0004;                // stray completion in ISSUE: ignored
    fpu_result = 32'h12345678;
    chk("t1_launch", fpu_op_valid, 13'h0004);
    chk("t1_opa",    fpu_opa, 32'h3F800000);
    chk("t1_opb",    fpu_opb, 32'h40000000);
    chk("t1_frm",    fpu_frm, 3'd1);
    tick();                               // WAIT1
    fpu_valids = 13'h0;
    chk("t1_one_pulse", fpu_op_valid, 13'h0);
    chk("t1_opa_hold",  fpu_opa, 32'h3F800000);
    chk("t1_no_early",  rsp_valid, 2'b00);
    tick();                               // WAIT2
    chk("t1_wait2", rsp_valid, 2'b00);
    fpu_valids = 13'h0004; fpu_result = 32'h40400000; fpu_exceptions = 5'h0;
    tick();                               // RESP
    fpu_valids = 13'h0; fpu_result = 32'hDEADBEEF;
    chk("t1_rsp_valid",  rsp_valid, 2'b01);
    chk("t1_rsp_result", rsp_result, 32'h40400000);
    chk("t1_rsp_flags",  rsp_flags, 5'h0);
    chk("t1_rsp_err",    rsp_err, 1'b0);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    chk("t1_rsp_drop", rsp_valid, 2'b00);

    // Round-robin with both requesters always valid; minimum-latency completion
    rst = 1'b1; tick(); rst = 1'b0;
    set_req(0, 13'h0008, 32'h11111111, 32'h0, 32'h0, 3'd2);
    set_req(1, 13'h0010, 32'h22222222, 32'h0, 32'h0, 3'd3);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_grant", req_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
      tick();                             // ISSUE
      chk("t2_launch", fpu_op_valid, (k % 2 == 1) ? 13'h0010 : 13'h0008);
      chk("t2_opa", fpu_opa, (k % 2 == 1) ? 32'h22222222 : 32'h11111111);
      tick();                             // WAIT1: complete immediately
      fpu_valids = (k % 2 == 1) ? 13'h0010 : 13'h0008;
      fpu_result = 32'hA0 + k;
      tick();                             // RESP, 3 cycles after accept
      fpu_valids = 13'h0;
      chk("t2_rsp_valid", rsp_valid, (k % 2 == 1) ? 2'b10 : 2'b01);
      chk("t2_rsp_result", rsp_result, 32'hA0 + k);
      chk("t2_no_accept", req_ready, 2'b00);
      rsp_ready = 2'b11;
      tick();
      rsp_ready = 2'b00;
    end
    req_valid = 2'b00;

    // Illegal op from requester 1, then a 5-cycle response stall
    set_req(1, 13'h0003, 32'h0, 32'h0, 32'h0, 3'd0);
    req_valid = 2'b10;
    #1;
    chk("t3_req_ready", req_ready, 2'b10);
    tick();                               // RESP directly
    set_req(0, 13'h0020, 32'h0, 32'h0, 32'h0, 3'd0);
    req_valid = 2'b11;
    chk("t3_no_launch", fpu_op_valid, 13'h0);
    chk("t3_rsp_valid", rsp_valid, 2'b10);
    chk("t3_err",       rsp_err, 1'b1);
    chk("t3_result",    rsp_result, 32'h0);
    rsp_ready = 2'b01;                    // non-granted ready must be ignored
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_valid",  rsp_valid, 2'b10);
      chk("t3_hold_err",    rsp_err, 1'b1);
      chk("t3_hold_flags",  rsp_flags, 5'h0);
      chk("t3_hold_noacc",  req_ready, 2'b00);
    end
    rsp_ready = 2'b10;
    tick();                               // IDLE
    rsp_ready = 2'b00;
    chk("t3_released", rsp_valid, 2'b00);
    chk("t3_next_grant", req_ready, 2'b01);
    req_valid = 2'b00;

    // Reset during WAIT abandons the op
    set_req(0, 13'h0004, 32'hCAFEF00D, 32'h1, 32'h2, 3'd4);
    req_valid = 2'b01;
    tick();                               // ISSUE
    req_valid = 2'b00;
    tick(); tick();                       // WAIT2
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_op_valid",  fpu_op_valid, 13'h0);
    chk("t4_rsp_valid", rsp_valid, 2'b00);
    chk("t4_opa",       fpu_opa, 32'h0);
    chk("t4_frm",       fpu_frm, 3'd0);
    chk("t4_result",    rsp_result, 32'h0);
    fpu_valids = 13'h0004; fpu_result = 32'h00001234;
    tick();
    fpu_valids = 13'h0;
    tick(); tick();
    chk("t4_no_rsp",    rsp_valid, 2'b00);
    chk("t4_no_launch", fpu_op_valid, 13'h0);

`ifdef FPU_SCHED_TIMEOUT_EN
    // Datapath never completes: timeout after 8 WAIT cycles
    fpu_result = 32'hBAD0BAD0;
    req_valid = 2'b01;
    tick();                               // ISSUE
    req_valid = 2'b00;
    repeat (8) tick();                    // WAIT8
    chk("t5_no_early", rsp_valid, 2'b00);
    tick();
    chk("t5_rsp_valid", rsp_valid, 2'b01);
    chk("t5_timeout",   rsp_timeout, 1'b1);
    chk("t5_result",    rsp_result, 32'h0);
    chk("t5_flags",     rsp_flags, 5'h0);
    rsp_ready = 2'b01; tick(); rsp_ready = 2'b00;
    // Completion on the limit cycle wins
    req_valid = 2'b01;
    tick();                               // ISSUE
    req_valid = 2'b00;
    repeat (8) tick();                    // WAIT8
    fpu_valids = 13'h0004; fpu_result = 32'h00000055; fpu_exceptions = 5'h01;
    tick();
    fpu_valids = 13'h0;
    chk("t5_late_valid",   rsp_valid, 2'b01);
    chk("t5_late_timeout", rsp_timeout, 1'b0);
    chk("t5_late_result",  rsp_result, 32'h00000055);
    chk("t5_late_flags",   rsp_flags, 5'h01);
    rsp_ready = 2'b01; tick(); rsp_ready = 2'b00;
`else
    // No timeout: WAIT persists well beyond 8 cycles
    req_valid = 2'b01;
    tick();                               // ISSUE
    req_valid = 2'b00;
    repeat (20) tick();
    chk("t5_still_wait", rsp_valid, 2'b00);
    fpu_valids = 13'h0004; fpu_result = 32'h00000077; fpu_exceptions = 5'h10;
    tick();
    fpu_valids = 13'h0;
    chk("t5_rsp_valid", rsp_valid, 2'b01);
    chk("t5_timeout",   rsp_timeout, 1'b0);
    chk("t5_result",    rsp_result, 32'h00000077);
    chk("t5_flags",     rsp_flags, 5'h10);
    rsp_ready = 2'b01; tick(); rsp_ready = 2'b00;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
